imm_synth: RTL and testbench
============================

Name: imm_synth

Overview:
- Inverse of the immediate-extension path: takes a 32-bit constant plus a destination register and emits the shortest I-type instruction sequence that materialises it.
- Used by the debug/boot instruction injector to load registers without a data-memory fetch.
- Each emitted word is tagged with the `IEXT_OP_*` code the decode-stage extender must apply, so the constant round-trips through the extender unchanged.

Parameters:
ALLOW_ADDIU, 1, 1 = use ADDIU for sign-extendable values; 0 = such values use the ORI or LUI/ORI forms instead
CNT_W, 16, width of the emitted-instruction counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  constant request valid
s_ready  output  1  request accepted when s_valid && s_ready
s_value  input  32  constant to materialise
s_rt  input  5  destination GPR
m_valid  output  1  instruction word valid
m_ready  input  1  consumer accepts word when m_valid && m_ready
m_instr  output  32  MIPS I-type word: opcode[31:26] rs[25:21] rt[20:16] imm[15:0]
m_iext_op  output  `IEXT_OP_LEN  extender op for m_instr (ZERO_EXT / SIGNED_EXT / SHIFTL16)
m_last  output  1  final word of the sequence
inst_cnt  output  CNT_W  count of words handed off, saturating

Behaviour:
- Reset (async assert, sync release): state=IDLE, s_ready=1, m_valid=0, m_instr=0, m_last=0, m_iext_op=`IEXT_OP_ZERO_EXT, inst_cnt=0.
- States:
  - IDLE: s_ready=1.
  - BEAT1, BEAT2: s_ready=0, m_valid=1.
- Acceptance latency: s_value and s_rt are captured on the handshake edge. The BEAT1 outputs are registered and valid the next cycle.
- Classification at capture, first match wins (hi = value[31:16], lo = value[15:0]):
  1. hi==0 → single ORI: opcode 001101, rs=0, imm=lo, op ZERO_EXT.
  2. ALLOW_ADDIU && value[31:15] all equal → single ADDIU: opcode 001001, rs=0, imm=lo, op SIGNED_EXT.
  3. lo==0 → single LUI: opcode 001111, rs=0, imm=hi, op SHIFTL16.
  4. Otherwise, two words:
     - BEAT1 = LUI rt,hi with m_last=0.
     - BEAT2 = ORI with rs=rt, rt=rt, imm=lo, op ZERO_EXT, m_last=1.
- Single-word classes: BEAT1 with m_last=1, then back to IDLE.
- s_rt==0: the request is accepted and dropped. No word is emitted and the block stays in IDLE, so s_ready stays 1.
- Output hold: m_instr, m_iext_op and m_last are held stable while m_valid && !m_ready. No word is ever dropped or repeated.
- Transitions:
  - BEAT1 → BEAT2 on handshake when m_last=0.
  - BEAT1 or BEAT2 → IDLE on handshake of a word with m_last=1.
  - No overlap: s_ready rises the cycle after the last handshake. Throughput is one constant per 2 cycles (1 word) or 3 cycles (2 words).
- inst_cnt increments by 1 on every m_valid && m_ready and saturates at all-ones.
- Reset mid-sequence: outputs drop to reset values immediately, the partial sequence is discarded and not resumed, and inst_cnt clears.
- s_value and s_rt are ignored when s_ready=0.
- m_valid never depends combinationally on m_ready.

Test Plan:
1. value=0x0000_1234, rt=8, m_ready=1 → one word 0x3408_1234, ZERO_EXT, last=1; s_ready high 2 cycles after accept; inst_cnt=1.
2. value=0xFFFF_8000, rt=9 → 0x2409_8000, SIGNED_EXT, last=1. Same stimulus with ALLOW_ADDIU=0 → 0x3C09_FFFF (last=0), then 0x3529_8000 (last=1).
3. value=0xABCD_0000, rt=10 → 0x3C0A_ABCD, SHIFTL16, last=1. value=0x0000_0000, rt=10 → 0x340A_0000 (ORI wins over ADDIU/LUI).
4. value=0x1234_5678, rt=4, m_ready low 3 cycles on each beat → 0x3C04_1234 held stable (last=0), then 0x3484_5678 held stable (last=1); s_ready=0 throughout; inst_cnt=2.
5. rt=0, any value → s_ready stays 1, m_valid never asserts, inst_cnt unchanged. Back-to-back s_valid with m_ready=1 → no request lost, words emitted in order.
6. rst_n low during BEAT2 of 0x1234_5678 → m_valid=0 asynchronously, inst_cnt=0, s_ready=1 after release, no stale BEAT2 emitted. Drive 2^CNT_W+3 words with CNT_W=4 → inst_cnt holds at 0xF.

Source files
------------

// File: rtl/imm_synth.sv
// ---------------------------------------------------------------------------
// imm_synth
//
// Turns a 32-bit constant and a destination GPR into the shortest MIPS
// I-type sequence that loads that constant. Each word carries the extender
// op the decode stage must apply, so the immediate comes back out of the
// extender exactly as it was put in.
//
// Used by the debug/boot instruction injector to fill registers without a
// data-memory fetch.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_valid    constant request valid
//   s_ready    request accepted when s_valid && s_ready (high only in IDLE)
//   s_value    constant to materialise
//   s_rt       destination GPR (0 = accept and drop)
//   m_valid    instruction word valid
//   m_ready    consumer accepts word when m_valid && m_ready
//   m_instr    I-type word: opcode[31:26] rs[25:21] rt[20:16] imm[15:0]
//   m_iext_op  extender op for m_instr (ZERO_EXT / SIGNED_EXT / SHIFTL16)
//   m_last     final word of the sequence
//   inst_cnt   number of words handed off, saturating at all-ones
//
// Parameters
//   ALLOW_ADDIU  1 = sign-extendable values use a single ADDIU
//                0 = those values fall through to the ORI / LUI / LUI+ORI forms
//   CNT_W        width of inst_cnt
// ---------------------------------------------------------------------------

// Extender op codes shared with the decode-stage immediate extender.
`ifndef IEXT_OP_LEN
`define IEXT_OP_LEN        2
`define IEXT_OP_ZERO_EXT   2'd0
`define IEXT_OP_SIGNED_EXT 2'd1
`define IEXT_OP_SHIFTL16   2'd2
`endif

module imm_synth #(
  parameter int ALLOW_ADDIU = 1,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [31:0]             s_value,
  input  logic [4:0]              s_rt,

  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [31:0]             m_instr,
  output logic [`IEXT_OP_LEN-1:0] m_iext_op,
  output logic                    m_last,

  output logic [CNT_W-1:0]        inst_cnt
);

  // MIPS opcodes used by the synthesiser.
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT1 = 2'd1;
  localparam logic [1:0] ST_BEAT2 = 2'd2;

  logic [1:0]              state;

  // Second-beat operands, captured with the request so BEAT2 does not
  // depend on s_value/s_rt after acceptance.
  logic [4:0]              rt_q;
  logic [15:0]             lo_q;

  // First-beat word chosen from the incoming constant.
  logic [15:0]             in_hi;
  logic [15:0]             in_lo;
  logic                    addiu_ok;
  logic [31:0]             first_instr;
  logic [`IEXT_OP_LEN-1:0] first_op;
  logic                    first_last;

  logic                    accept;
  logic                    fire;

  // Handshake flags. Both valid/ready come straight from the state register,
  // so m_valid never depends on m_ready within a cycle.
  always_comb begin
    s_ready = (state == ST_IDLE);
    m_valid = (state == ST_BEAT1) || (state == ST_BEAT2);
    accept  = s_valid && s_ready;
    fire    = m_valid && m_ready;
  end

  // Pick the shortest form for the incoming constant. Order matters:
  // zero-upper values always go out as ORI (so 0 becomes ORI, not ADDIU or
  // LUI), then sign-extendable values as ADDIU if enabled, then values with
  // a zero low half as LUI, and everything else as LUI followed by ORI.
  always_comb begin
    in_hi       = s_value[31:16];
    in_lo       = s_value[15:0];
    addiu_ok    = (ALLOW_ADDIU != 0) &&
                  ((&s_value[31:15]) || (~|s_value[31:15]));
    first_instr = {OP_LUI, 5'd0, s_rt, in_hi};
    first_op    = `IEXT_OP_SHIFTL16;
    first_last  = 1'b0;
    if (in_hi == 16'h0000) begin
      first_instr = {OP_ORI, 5'd0, s_rt, in_lo};
      first_op    = `IEXT_OP_ZERO_EXT;
      first_last  = 1'b1;
    end else if (addiu_ok) begin
      first_instr = {OP_ADDIU, 5'd0, s_rt, in_lo};
      first_op    = `IEXT_OP_SIGNED_EXT;
      first_last  = 1'b1;
    end else if (in_lo == 16'h0000) begin
      first_instr = {OP_LUI, 5'd0, s_rt, in_hi};
      first_op    = `IEXT_OP_SHIFTL16;
      first_last  = 1'b1;
    end
  end

  // Sequencer. Output registers only change on acceptance or on a word
  // handshake, which keeps m_instr/m_iext_op/m_last stable under
  // backpressure. A request for r0 is consumed but produces nothing, so
  // the block simply stays in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      m_instr   <= 32'h0000_0000;
      m_iext_op <= `IEXT_OP_ZERO_EXT;
      m_last    <= 1'b0;
      rt_q      <= 5'd0;
      lo_q      <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (s_rt != 5'd0)) begin
            state     <= ST_BEAT1;
            m_instr   <= first_instr;
            m_iext_op <= first_op;
            m_last    <= first_last;
            rt_q      <= s_rt;
            lo_q      <= in_lo;
          end
        end
        ST_BEAT1: begin
          if (fire) begin
            if (m_last) begin
              state <= ST_IDLE;
            end else begin
              // The ORI reads back the LUI result, so rs and rt are both the
              // destination register.
              state     <= ST_BEAT2;
              m_instr   <= {OP_ORI, rt_q, rt_q, lo_q};
              m_iext_op <= `IEXT_OP_ZERO_EXT;
              m_last    <= 1'b1;
            end
          end
        end
        ST_BEAT2: begin
          if (fire) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handed-off word counter, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_cnt <= '0;
    end else if (fire && (inst_cnt != {CNT_W{1'b1}})) begin
      inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_synth.sv
// ---------------------------------------------------------------------------
// tb_imm_synth
//
// Three instances of imm_synth share clock, reset and request data:
//   dut 0 : default parameters
//   dut 1 : ALLOW_ADDIU = 0
//   dut 2 : CNT_W = 4 (counter saturation)
// Expected word sequences come from a reference model that classifies the
// constant with plain integer arithmetic.
// ---------------------------------------------------------------------------

`ifndef IEXT_OP_LEN
`define IEXT_OP_LEN        2
`define IEXT_OP_ZERO_EXT   2'd0
`define IEXT_OP_SIGNED_EXT 2'd1
`define IEXT_OP_SHIFTL16   2'd2
`endif

module tb_imm_synth;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_value;
  logic [4:0]  s_rt;

  logic                    sv  [0:2];
  logic                    sr  [0:2];
  logic                    mv  [0:2];
  logic                    mr  [0:2];
  logic [31:0]             mi  [0:2];
  logic [`IEXT_OP_LEN-1:0] mo  [0:2];
  logic                    ml  [0:2];
  logic [15:0]             cnt0;
  logic [15:0]             cnt1;
  logic [3:0]              cnt2;

  int          checks;
  int          errors;
  logic [15:0] cntModel [0:2];

  // Clock generation: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  imm_synth #(.ALLOW_ADDIU(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sv[0]), .s_ready(sr[0]), .s_value(s_value), .s_rt(s_rt),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_instr(mi[0]), .m_iext_op(mo[0]),
    .m_last(ml[0]), .inst_cnt(cnt0)
  );

  imm_synth #(.ALLOW_ADDIU(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sv[1]), .s_ready(sr[1]), .s_value(s_value), .s_rt(s_rt),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_instr(mi[1]), .m_iext_op(mo[1]),
    .m_last(ml[1]), .inst_cnt(cnt1)
  );

  imm_synth #(.ALLOW_ADDIU(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sv[2]), .s_ready(sr[2]), .s_value(s_value), .s_rt(s_rt),
    .m_valid(mv[2]), .m_ready(mr[2]), .m_instr(mi[2]), .m_iext_op(mo[2]),
    .m_last(ml[2]), .inst_cnt(cnt2)
  );

  // Counter value of instance k, widened to a common width.
  function automatic logic [15:0] cntOf(input int k);
    if (k == 0) return cnt0;
    if (k == 1) return cnt1;
    return {12'd0, cnt2};
  endfunction

  function automatic logic [15:0] cntMax(input int k);
    return (k == 2) ? 16'h000F : 16'hFFFF;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: the word list for a constant, derived from its
  // numeric value rather than from bit patterns.
  task automatic modelWords(input logic [31:0] value, input logic [4:0] rt,
                            input bit allow, output int n,
                            output logic [31:0] wInstr [0:1],
                            output logic [1:0] wOp [0:1]);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = 16'(value / 32'd65536);
    lo = 16'(value % 32'd65536);
    wInstr[1] = 32'd0;
    wOp[1]    = `IEXT_OP_ZERO_EXT;
    if (rt == 5'd0) begin
      n = 0;
      wInstr[0] = 32'd0;
      wOp[0]    = `IEXT_OP_ZERO_EXT;
    end else if (value < 32'd65536) begin
      n = 1;
      wInstr[0] = {6'b001101, 5'd0, rt, lo};
      wOp[0]    = `IEXT_OP_ZERO_EXT;
    end else if (allow && (value >= 32'hFFFF_8000)) begin
      n = 1;
      wInstr[0] = {6'b001001, 5'd0, rt, lo};
      wOp[0]    = `IEXT_OP_SIGNED_EXT;
    end else if (lo == 16'd0) begin
      n = 1;
      wInstr[0] = {6'b001111, 5'd0, rt, hi};
      wOp[0]    = `IEXT_OP_SHIFTL16;
    end else begin
      n = 2;
      wInstr[0] = {6'b001111, 5'd0, rt, hi};
      wOp[0]    = `IEXT_OP_SHIFTL16;
      wInstr[1] = {6'b001101, rt, rt, lo};
      wOp[1]    = `IEXT_OP_ZERO_EXT;
    end
  endtask

  // Issue one constant to instance k and consume its words.
  // mode 0 = random m_ready, 1 = always ready, 2 = ready low 3 cycles per word.
  task automatic applyStimulus(input int k, input logic [31:0] value,
                               input logic [4:0] rt, input int mode);
    int          n;
    int          guard;
    int          waitCnt;
    bit          done;
    logic [31:0] wInstr [0:1];
    logic [1:0]  wOp    [0:1];
    modelWords(value, rt, (k != 1), n, wInstr, wOp);

    guard = 0;
    while (!sr[k] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!sr[k]) begin
      checkOutput("s_ready_timeout", 32'(sr[k]), 32'd1);
      return;
    end

    sv[k]   = 1'b1;
    s_value = value;
    s_rt    = rt;
    @(posedge clk); #1;
    sv[k]   = 1'b0;
    s_value = $urandom;
    s_rt    = 5'($urandom);

    for (int w = 0; w < n; w++) begin
      waitCnt = 0;
      done    = 1'b0;
      while (!done) begin
        checkOutput("m_valid",   32'(mv[k]), 32'd1);
        checkOutput("s_ready_busy", 32'(sr[k]), 32'd0);
        checkOutput("m_instr",   mi[k], wInstr[w]);
        checkOutput("m_iext_op", 32'(mo[k]), 32'(wOp[w]));
        checkOutput("m_last",    32'(ml[k]), 32'(w == n - 1));
        if (mode == 1)      mr[k] = 1'b1;
        else if (mode == 2) mr[k] = (waitCnt >= 3);
        else                mr[k] = ($urandom_range(0, 2) != 0);
        if (waitCnt > 40) mr[k] = 1'b1;
        @(posedge clk); #1;
        waitCnt++;
        if (mr[k]) begin
          done = 1'b1;
          if (cntModel[k] != cntMax(k)) cntModel[k] = cntModel[k] + 16'd1;
        end
      end
      mr[k] = 1'b0;
    end

    checkOutput("s_ready_after", 32'(sr[k]), 32'd1);
    checkOutput("m_valid_after", 32'(mv[k]), 32'd0);
    checkOutput("inst_cnt", 32'(cntOf(k)), 32'(cntModel[k]));
  endtask

  // Random constant biased towards every classification boundary.
  function automatic logic [31:0] randValue();
    case ($urandom_range(0, 5))
      0: return {16'h0000, 16'($urandom)};
      1: return {17'h1FFFF, 15'($urandom)};
      2: return {16'($urandom), 16'h0000};
      3: return $urandom_range(0, 1) ? 32'h0000_0000 : 32'hFFFF_FFFF;
      4: return $urandom_range(0, 1) ? 32'hFFFF_7FFF : 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    s_value = 32'd0;
    s_rt    = 5'd0;
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0;
      mr[i] = 1'b0;
      cntModel[i] = 16'd0;
    end

    // Reset state.
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_s_ready", 32'(sr[i]), 32'd1);
      checkOutput("rst_m_valid", 32'(mv[i]), 32'd0);
      checkOutput("rst_m_instr", mi[i], 32'd0);
      checkOutput("rst_m_iext_op", 32'(mo[i]), 32'(`IEXT_OP_ZERO_EXT));
      checkOutput("rst_m_last", 32'(ml[i]), 32'd0);
      checkOutput("rst_inst_cnt", 32'(cntOf(i)), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    applyStimulus(0, 32'h0000_1234, 5'd8, 1);
    applyStimulus(0, 32'hFFFF_8000, 5'd9, 1);
    applyStimulus(1, 32'hFFFF_8000, 5'd9, 1);
    applyStimulus(0, 32'hABCD_0000, 5'd10, 1);
    applyStimulus(0, 32'h0000_0000, 5'd10, 1);
    applyStimulus(1, 32'h0000_0000, 5'd10, 1);
    applyStimulus(0, 32'h1234_5678, 5'd4, 2);
    applyStimulus(0, 32'hDEAD_BEEF, 5'd0, 1);
    applyStimulus(0, 32'h0000_0042, 5'd0, 0);

    // Randomized traffic on both classification variants.
    for (int t = 0; t < 150; t++) begin
      applyStimulus(0, randValue(), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 0);
    end
    for (int t = 0; t < 60; t++) begin
      applyStimulus(1, randValue(), 5'($urandom_range(0, 31)), 0);
    end

    // Reset while BEAT2 of a two-word sequence is pending.
    sv[0] = 1'b1; s_value = 32'h1234_5678; s_rt = 5'd4;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    checkOutput("mid_beat1", mi[0], 32'h3C04_1234);
    mr[0] = 1'b1;
    @(posedge clk); #1;
    mr[0] = 1'b0;
    checkOutput("mid_beat2", mi[0], 32'h3484_5678);
    checkOutput("mid_beat2_valid", 32'(mv[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_m_valid", 32'(mv[0]), 32'd0);
    checkOutput("async_inst_cnt", 32'(cntOf(0)), 32'd0);
    checkOutput("async_s_ready", 32'(sr[0]), 32'd1);
    for (int i = 0; i < 3; i++) cntModel[i] = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    mr[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput("no_stale_beat2", 32'(mv[0]), 32'd0);
      checkOutput("post_rst_s_ready", 32'(sr[0]), 32'd1);
    end
    mr[0] = 1'b0;
    checkOutput("post_rst_cnt", 32'(cntOf(0)), 32'd0);

    // Saturation of the 4-bit counter: 2^4 + 3 words.
    for (int t = 0; t < 19; t++) begin
      applyStimulus(2, 32'(t + 1), 5'($urandom_range(1, 31)), 1);
    end
    checkOutput("sat_cnt", 32'(cntOf(2)), 32'h0000_000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
